// File: rtl/branch_predict_cmp_if.sv
// Bundle of signals between the IF/ID pipeline stages and the branch
// comparator/predictor. The pipeline drives through the master modport;
// the predictor implements the slave side.
interface branch_predict_cmp_if #(
  parameter int WIDTH = 32
);
  // Fetch-side prediction lookup
  logic [31:0]      if_pc;
  logic             pred_taken;
  // ID-stage resolution inputs
  logic             res_valid;
  logic             res_stall;
  logic [31:0]      res_pc;
  logic [31:0]      res_instr;
  logic             res_pred;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  // ID-stage resolution outputs
  logic             is_branch;
  logic             cmp_jump;
  logic             is_link;
  logic             mispredict;
  logic             redirect_taken;
  // Statistics
  logic             stat_clr;
  logic [31:0]      branch_cnt;
  logic [31:0]      mispred_cnt;

  modport master (
    output if_pc, res_valid, res_stall, res_pc, res_instr, res_pred, rs, rt, stat_clr,
    input  pred_taken, is_branch, cmp_jump, is_link, mispredict, redirect_taken,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, res_valid, res_stall, res_pc, res_instr, res_pred, rs, rt, stat_clr,
    output pred_taken, is_branch, cmp_jump, is_link, mispredict, redirect_taken,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_cmp.sv
// Branch condition comparator with a 2-bit saturating-counter pattern
// history table. Fetch gets a combinational prediction per PC; the ID stage
// gets the resolved condition, a registered mispredict pulse with the actual
// direction, a PHT update and resolved/mispredicted branch counters.
module branch_predict_cmp #(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 64,
  parameter int IDX_BITS  = $clog2(PHT_DEPTH)
) (
  input logic clk,
  input logic reset_n,
  branch_predict_cmp_if.slave bus
);

  localparam logic [1:0] ST_SN = 2'b00;
  localparam logic [1:0] ST_WN = 2'b01;
  localparam logic [1:0] ST_ST = 2'b11;

  // Counters are kept in flops rather than RAM: every entry must return to
  // WN on an asynchronous reset.
  logic [1:0]          pht_reg [PHT_DEPTH];
  logic [1:0]          pht_next;
  logic [1:0]          pht_cur;
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;

  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic        rs_neg;
  logic        rs_zero;
  logic        is_branch_c;
  logic        cmp_jump_c;
  logic        is_link_c;
  logic        commit;
  logic        mispred_c;

  logic        mispredict_reg;
  logic        redirect_taken_reg;
  logic [31:0] branch_cnt_reg;
  logic [31:0] mispred_cnt_reg;

  // Address bits above the index alias on purpose; instruction fields not
  // involved in branch decode are ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.if_pc[31:IDX_BITS+2], bus.if_pc[1:0],
                         bus.res_pc[31:IDX_BITS+2], bus.res_pc[1:0],
                         bus.res_instr[25:21], bus.res_instr[15:0]};

  assign opcode   = bus.res_instr[31:26];
  assign rt_field = bus.res_instr[20:16];
  assign rs_neg   = bus.rs[WIDTH-1];
  assign rs_zero  = (bus.rs == '0);

  // Branch decode and condition evaluation (signed compares against zero)
  always_comb begin
    is_branch_c = 1'b0;
    cmp_jump_c  = 1'b0;
    is_link_c   = 1'b0;
    case (opcode)
      6'h04: begin is_branch_c = 1'b1; cmp_jump_c = (bus.rs == bus.rt); end
      6'h05: begin is_branch_c = 1'b1; cmp_jump_c = (bus.rs != bus.rt); end
      6'h06: begin is_branch_c = 1'b1; cmp_jump_c = rs_neg | rs_zero; end
      6'h07: begin is_branch_c = 1'b1; cmp_jump_c = ~rs_neg & ~rs_zero; end
      6'h01: begin
        case (rt_field)
          5'b00001: begin is_branch_c = 1'b1; cmp_jump_c = ~rs_neg; end
          5'b00000: begin is_branch_c = 1'b1; cmp_jump_c = rs_neg; end
          5'b10001: begin is_branch_c = 1'b1; cmp_jump_c = ~rs_neg; is_link_c = 1'b1; end
          5'b10000: begin is_branch_c = 1'b1; cmp_jump_c = rs_neg;  is_link_c = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign commit    = bus.res_valid & is_branch_c & ~bus.res_stall;
  assign mispred_c = commit & (bus.res_pred != cmp_jump_c);

  assign rd_idx = bus.if_pc[IDX_BITS+1:2];
  assign wr_idx = bus.res_pc[IDX_BITS+1:2];
  assign pht_cur = pht_reg[wr_idx];

  // Saturating counter step for the entry being resolved
  always_comb begin
    pht_next = pht_cur;
    if (cmp_jump_c) begin
      if (pht_cur != ST_ST) pht_next = pht_cur + 2'd1;
    end else begin
      if (pht_cur != ST_SN) pht_next = pht_cur - 2'd1;
    end
  end

  // PHT state: all entries weakly not-taken after reset, one entry updated per commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_reg[i] <= ST_WN;
    end else if (commit) begin
      pht_reg[wr_idx] <= pht_next;
    end
  end

  // Mispredict pulse and sticky redirect direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_reg     <= 1'b0;
      redirect_taken_reg <= 1'b0;
    end else begin
      mispredict_reg <= mispred_c;
      if (mispred_c) redirect_taken_reg <= cmp_jump_c;
    end
  end

  // Statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt_reg  <= 32'd0;
      mispred_cnt_reg <= 32'd0;
    end else if (bus.stat_clr) begin
      branch_cnt_reg  <= 32'd0;
      mispred_cnt_reg <= 32'd0;
    end else begin
      if (commit)    branch_cnt_reg  <= branch_cnt_reg + 32'd1;
      if (mispred_c) mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end

  // Lookup reads the pre-update table value; no write bypass
  assign bus.pred_taken     = pht_reg[rd_idx][1];
  assign bus.is_branch      = is_branch_c;
  assign bus.cmp_jump       = cmp_jump_c;
  assign bus.is_link        = is_link_c;
  assign bus.mispredict     = mispredict_reg;
  assign bus.redirect_taken = redirect_taken_reg;
  assign bus.branch_cnt     = branch_cnt_reg;
  assign bus.mispred_cnt    = mispred_cnt_reg;

endmodule

// File: doc/branch_predict_cmp.md
# branch_predict_cmp

Branch condition comparator with a built-in 2-bit saturating-counter pattern history table (PHT), parametrised in operand width and table depth. It sits across IF/ID of the pipelined MIPS core. IF gets a taken/not-taken prediction per fetch PC. ID gets the resolved condition (beq/bne/blez/bgtz/bgez/bltz/bgezal/bltzal), a registered mispredict pulse for flush control, a PHT update and performance counters.

## Interface
Parameters:
- WIDTH, 32, operand width of rs/rt compared.
- PHT_DEPTH, 64, PHT entries; power of two, 4..1024.
- IDX_BITS, $clog2(PHT_DEPTH), PHT index width, derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  fetch PC for prediction lookup.
- pred_taken  out  1  combinational; MSB of PHT[if_pc[IDX_BITS+1:2]].
- res_valid  in  1  ID-stage instruction valid.
- res_stall  in  1  ID stalled; suppresses all state updates.
- res_pc  in  32  PC of the ID-stage instruction.
- res_instr  in  32  ID-stage instruction word.
- res_pred  in  1  prediction carried down the pipe with this instruction.
- rs  in  WIDTH  forwarded rs value.
- rt  in  WIDTH  forwarded rt value.
- is_branch  out  1  combinational; res_instr decodes as a supported branch.
- cmp_jump  out  1  combinational; branch condition true (0 when not a branch).
- is_link  out  1  combinational; bgezal/bltzal.
- mispredict  out  1  registered one-cycle pulse; reset 0.
- redirect_taken  out  1  registered; actual direction for the mispredicted branch; reset 0.
- stat_clr  in  1  synchronous clear of both statistics counters.
- branch_cnt  out  32  resolved-branch count; reset 0.
- mispred_cnt  out  32  mispredicted-branch count; reset 0.

## Operation
- Decode uses opcode = instr[31:26] and rt field = instr[20:16]:
  - 0x04 beq: rs==rt.
  - 0x05 bne: rs!=rt.
  - 0x06 blez: signed rs<=0.
  - 0x07 bgtz: signed rs>0.
  - 0x01 with rt field 00001 bgez: signed rs>=0.
  - 0x01 with rt field 00000 bltz: signed rs<0.
  - 0x01 with rt field 10001 bgezal: signed rs>=0; is_link=1.
  - 0x01 with rt field 10000 bltzal: signed rs<0; is_link=1.
  - Any other encoding: is_branch=cmp_jump=is_link=0.
- All signed compares are at WIDTH bits. rt is ignored except for beq/bne.
- Define `commit = res_valid & is_branch & ~res_stall`.
- PHT entry states: SN=00, WN=01, WT=10, ST=11. Reset value is WN for every entry.
- PHT update on commit, at index res_pc[IDX_BITS+1:2]:
  - cmp_jump=1: increment, saturating at ST.
  - cmp_jump=0: decrement, saturating at SN.
- Mispredict on commit when res_pred != cmp_jump:
  - mispredict=1 the next cycle.
  - redirect_taken=cmp_jump, held until the next mispredict.
- Outside a mispredict, mispredict=0. redirect_taken is updated only on a mispredict.
- Statistics:
  - branch_cnt += 1 on each commit.
  - mispred_cnt += 1 on each mispredicting commit.
  - Both wrap modulo 2^32.
  - stat_clr has priority over an increment in the same cycle; the result is 0.
- Stall or invalid: no PHT change, no counter change, mispredict=0 next cycle.

## Timing
- pred_taken, is_branch, cmp_jump, is_link: zero-latency combinational.
- PHT update, counters, mispredict: visible one cycle after the commit edge.
- Same-index read/write in one cycle: pred_taken returns the pre-update value; no bypass.
- Back-to-back mispredicts produce mispredict high on consecutive cycles, each with its own redirect_taken.
- reset_n low at any time, including mid-stream, has immediate asynchronous effect:
  - all PHT entries go to WN;
  - mispredict, redirect_taken, branch_cnt and mispred_cnt go to 0.
- The first edge after deassertion behaves as a normal cycle.
- The PC aliasing is intentional: PCs differing only above bit IDX_BITS+1 share an entry.

## Test plan
- Reset/initial lookup:
  - reset_n low, then high; if_pc=0x3000 -> pred_taken=0 (WN).
  - All outputs and counters are 0 after reset.
- Compare coverage, WIDTH=32:
  - beq rs=rt=0x5 -> cmp_jump=1.
  - blez rs=0x80000000 -> 1.
  - bgtz rs=0 -> 0.
  - bgezal rs=0 -> cmp_jump=1, is_link=1.
  - opcode 0x01 with rt field 00011 -> is_branch=0.
- Saturation:
  - Three taken commits of beq at res_pc=0x3010 -> pred_taken=1 at if_pc=0x3010.
  - One not-taken commit -> still 1 (ST->WT).
  - A second not-taken commit -> 0.
- Mispredict:
  - Commit with res_pred=0 and cmp_jump=1 -> next cycle mispredict=1, redirect_taken=1, mispred_cnt=1, branch_cnt=1.
  - The cycle after that -> mispredict=0.
- Stall/clear:
  - res_stall=1 with a mispredicting branch -> no PHT change, no mispredict, counters unchanged.
  - stat_clr together with a commit -> both counters read 0.
- Parametrisation:
  - WIDTH=16, PHT_DEPTH=4: bltz rs=0x8000 -> taken.
  - PCs 0x3000 and 0x3010 alias to the same entry; an update via one is visible via the other.
